// File: rtl/sqrt_pkg.sv
// Shared types and widths for the SquareRoot scheduler.
// Operand widths match the SquareRoot datapath interface.
package sqrt_pkg;

    localparam int SQRT_A_W = 12;
    localparam int SQRT_Q_W = 24;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/sqrt_scheduler_rr_arbiter.sv
// Combinational round-robin picker.
// Grants the first asserted request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    // scan N positions starting at ptr, first hit wins
    always_comb begin
        int  idx;
        logic found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/sqrt_scheduler.sv
// Shares one SquareRoot unit among N_REQ requesters.
// One job in flight: grant, start pulse, fixed wait, then respond.
module sqrt_scheduler
    import sqrt_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int SQRT_LATENCY = 24
) (
    input  logic                              clk,
    input  logic                              rst_,
    input  logic [N_REQ-1:0]                  req_valid,
    input  logic [N_REQ-1:0][SQRT_A_W-1:0]    req_a,
    output logic [N_REQ-1:0]                  req_ready,
    output logic                              resp_valid,
    output logic [$clog2(N_REQ)-1:0]          resp_id,
    output logic [SQRT_Q_W-1:0]               resp_q,
    input  logic                              resp_ready,
    output logic                              sqrt_start,
    output logic [SQRT_A_W-1:0]               sqrt_a,
    input  logic [SQRT_Q_W-1:0]               sqrt_q
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(SQRT_LATENCY + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(SQRT_LATENCY - 1);
    localparam logic [IW-1:0] LAST_ID  = IW'(N_REQ - 1);

    state_t                r_state;
    state_t                w_next;
    logic [IW-1:0]         r_ptr;
    logic [IW-1:0]         r_id;
    logic [SQRT_A_W-1:0]   r_a;
    logic [CW-1:0]         r_cnt;
    logic                  r_resp_valid;
    logic [IW-1:0]         r_resp_id;
    logic [SQRT_Q_W-1:0]   r_resp_q;

    logic [N_REQ-1:0]      w_gnt;
    logic [IW-1:0]         w_gnt_idx;
    logic                  w_xfer;
    logic                  w_done;
    logic                  w_hs;

    rr_arbiter #(
        .N  (N_REQ),
        .IW (IW)
    ) u_arb (
        .req     (req_valid),
        .ptr     (r_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    assign w_xfer = (r_state == IDLE) && (|w_gnt);
    assign w_done = (r_state == WAIT) && (r_cnt == '0);
    assign w_hs   = (r_state == RESP) && resp_ready;

    assign sqrt_a     = r_a;
    assign resp_valid = r_resp_valid;
    assign resp_id    = r_resp_id;
    assign resp_q     = r_resp_q;

    // next state plus grant and start strobes
    always_comb begin
        w_next     = r_state;
        req_ready  = '0;
        sqrt_start = 1'b0;
        unique case (r_state)
            IDLE: begin
                req_ready = w_gnt;
                if (w_xfer) w_next = ISSUE;
            end
            ISSUE: begin
                sqrt_start = 1'b1;
                w_next     = WAIT;
            end
            WAIT: begin
                if (w_done) w_next = RESP;
            end
            RESP: begin
                if (resp_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) r_state <= IDLE;
        else      r_state <= w_next;
    end

    // capture the winner and advance the round-robin pointer past it
    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            r_ptr <= '0;
            r_id  <= '0;
            r_a   <= '0;
        end else if (w_xfer) begin
            r_id  <= w_gnt_idx;
            r_a   <= req_a[w_gnt_idx];
            r_ptr <= (w_gnt_idx == LAST_ID) ? '0 : w_gnt_idx + IW'(1);
        end
    end

    // latency countdown, loaded while the start pulse is out
    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            r_cnt <= '0;
        end else if (r_state == ISSUE) begin
            r_cnt <= CNT_LOAD;
        end else if ((r_state == WAIT) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    // response register, held until the consumer accepts
    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            r_resp_valid <= 1'b0;
            r_resp_id    <= '0;
            r_resp_q     <= '0;
        end else if (w_done) begin
            r_resp_valid <= 1'b1;
            r_resp_id    <= r_id;
            r_resp_q     <= sqrt_q;
        end else if (w_hs) begin
            r_resp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sqrt_scheduler.sv
// Bench for sqrt_scheduler with a behavioural fixed-latency SquareRoot.
// Transaction-level model checked against the DUT every cycle.
module tb_sqrt_scheduler;
    import sqrt_pkg::*;

    localparam int N  = 4;
    localparam int L  = 24;
    localparam int IW = $clog2(N);

    logic                         clk = 1'b0;
    logic                         rst_;
    logic [N-1:0]                 req_valid;
    logic [N-1:0][SQRT_A_W-1:0]   req_a;
    logic [N-1:0]                 req_ready;
    logic                         resp_valid;
    logic [IW-1:0]                resp_id;
    logic [SQRT_Q_W-1:0]          resp_q;
    logic                         resp_ready;
    logic                         sqrt_start;
    logic [SQRT_A_W-1:0]          sqrt_a;
    logic [SQRT_Q_W-1:0]          sqrt_q;

    always #5 clk = ~clk;

    sqrt_scheduler #(
        .N_REQ        (N),
        .SQRT_LATENCY (L)
    ) dut (
        .clk        (clk),
        .rst_       (rst_),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_q     (resp_q),
        .resp_ready (resp_ready),
        .sqrt_start (sqrt_start),
        .sqrt_a     (sqrt_a),
        .sqrt_q     (sqrt_q)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // Q = floor(sqrt(A * 2^36)), i.e. sqrt(A) with 18 fraction bits
    function automatic logic [23:0] isqrt(input logic [11:0] a);
        longint unsigned v, r, t;
        v = 64'(a) << 36;
        r = 0;
        for (int b = 23; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (t * t <= v) r = t;
        end
        return r[23:0];
    endfunction

    // SquareRoot stand-in: Q is only correct exactly L cycles after start
    int          s_cnt;
    logic [11:0] s_a;
    always @(posedge clk or posedge rst_) begin
        if (rst_) begin
            s_cnt <= 0;
            s_a   <= '0;
        end else if (sqrt_start) begin
            s_cnt <= 1;
            s_a   <= sqrt_a;
        end else if (s_cnt != 0 && s_cnt <= L) begin
            s_cnt <= s_cnt + 1;
        end
    end
    assign sqrt_q = (s_cnt == L) ? isqrt(s_a) : (24'hC3C3C3 ^ {12'd0, s_a});

    // requesters drop valid once accepted unless told to keep streaming
    logic [N-1:0] acc  = '0;
    logic [N-1:0] keep = '0;
    always @(negedge clk) acc = req_valid & req_ready;
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                if (keep[i]) req_a[i] = 12'($urandom);
                else         req_valid[i] = 1'b0;
            end
        end
        acc = '0;
    end

    // model state and logs of observed DUT events
    int          cyc = 0;
    bit          m_busy = 0;
    int          m_t0 = 0;
    int          m_id = 0;
    logic [11:0] m_a = '0;
    int          m_ptr = 0;
    logic        prev_rv = 1'b0;
    logic [N-1:0] p_hold = '0;
    logic [N-1:0][11:0] p_a;

    int          xf_cyc[$];
    int          xf_id[$];
    int          st_cyc[$];
    int          rs_cyc[$];
    int          rs_id[$];
    logic [23:0] rs_q[$];
    int          hs_cyc[$];

    always @(negedge clk) begin : cmp
        logic [N-1:0] er;
        int           g;
        bit           erv;
        int           xid;
        cyc++;
        if (rst_) begin
            chk("rst_outs", {req_ready, resp_valid, resp_id, resp_q,
                             sqrt_start, sqrt_a}, 64'd0);
            m_busy  = 0;
            m_ptr   = 0;
            prev_rv = 1'b0;
            p_hold  = '0;
        end else begin
            for (int i = 0; i < N; i++)
                if (p_hold[i])
                    chk("proto_hold", {req_valid[i], req_a[i]}, {1'b1, p_a[i]});
            er = '0;
            g  = -1;
            if (!m_busy)
                for (int k = 0; k < N; k++)
                    if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            if (g >= 0) er[g] = 1'b1;
            erv = m_busy && (cyc >= m_t0 + 2 + L);
            chk("req_ready", req_ready, er);
            chk("sqrt_start", sqrt_start, m_busy && (cyc == m_t0 + 1));
            chk("resp_valid", resp_valid, erv);
            if (m_busy && cyc > m_t0) chk("sqrt_a", sqrt_a, m_a);
            if (erv) begin
                chk("resp_id", resp_id, m_id);
                chk("resp_q", resp_q, isqrt(m_a));
            end
            if (|(req_valid & req_ready)) begin
                xid = -1;
                for (int i = 0; i < N; i++)
                    if (xid < 0 && req_valid[i] && req_ready[i]) xid = i;
                xf_cyc.push_back(cyc);
                xf_id.push_back(xid);
            end
            if (sqrt_start) st_cyc.push_back(cyc);
            if (resp_valid && !prev_rv) begin
                rs_cyc.push_back(cyc);
                rs_id.push_back(int'(resp_id));
                rs_q.push_back(resp_q);
            end
            if (resp_valid && resp_ready) hs_cyc.push_back(cyc);
            prev_rv = resp_valid;
            p_hold  = req_valid & ~req_ready;
            p_a     = req_a;
            if (g >= 0) begin
                m_busy = 1;
                m_t0   = cyc;
                m_id   = g;
                m_a    = req_a[g];
                m_ptr  = (g + 1) % N;
            end else if (erv && resp_ready) begin
                m_busy = 0;
            end
        end
    end

    task automatic post(input int i, input logic [11:0] a);
        req_valid[i] = 1'b1;
        req_a[i]     = a;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_hs(input string nm, input int target, input int budget);
        int k = 0;
        while (hs_cyc.size() < target && k < budget) begin
            @(posedge clk);
            k++;
        end
        #2;
        chk(nm, hs_cyc.size(), target);
    endtask

    task automatic wait_xf(input string nm, input int target, input int budget);
        int k = 0;
        while (xf_cyc.size() < target && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk(nm, xf_cyc.size(), target);
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while ((req_valid != '0 || m_busy) && k < budget) begin
            @(posedge clk);
            k++;
        end
        #2;
        chk("drain", {req_valid, resp_valid}, 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int xb, rb, hb, n;
        logic [11:0] a;
        rst_       = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        resp_ready = 1'b1;

        chk("model_0",   isqrt(12'h000), 24'h000000);
        chk("model_004", isqrt(12'h004), 24'h080000);
        chk("model_100", isqrt(12'h100), 24'h400000);
        chk("model_900", isqrt(12'h900), 24'hC00000);
        chk("model_fff", isqrt(12'hFFF), 24'hFFF7FF);

        step(3);
        rst_ = 1'b0;
        step(1);

        // single request, latency
        post(2, 12'hF00);
        wait_hs("t1_done", 1, 200);
        chk("t1_id", xf_id[0], 2);
        chk("t1_start_lat", st_cyc[0] - xf_cyc[0], 1);
        chk("t1_resp_lat", rs_cyc[0] - xf_cyc[0], L + 2);
        chk("t1_rid", rs_id[0], 2);
        chk("t1_q", rs_q[0], isqrt(12'hF00));

        // all four from reset, then wrap
        rst_ = 1'b1;
        step(2);
        rst_ = 1'b0;
        step(1);
        xb = xf_id.size();
        rb = rs_q.size();
        hb = hs_cyc.size();
        post(0, 12'h100);
        post(1, 12'h004);
        post(2, 12'h900);
        post(3, 12'hFFF);
        wait_hs("t2_done", hb + 4, 600);
        for (int k = 0; k < 4; k++) begin
            chk("t2_order", xf_id[xb + k], k);
            chk("t2_rid", rs_id[rb + k], k);
        end
        chk("t2_q0", rs_q[rb + 0], 24'h400000);
        chk("t2_q1", rs_q[rb + 1], 24'h080000);
        chk("t2_q2", rs_q[rb + 2], 24'hC00000);
        chk("t2_q3", rs_q[rb + 3], 24'hFFF7FF);
        post(1, 12'h010);
        post(0, 12'h020);
        wait_hs("t2_wrap_done", hb + 6, 300);
        chk("t2_wrap0", xf_id[xb + 4], 0);
        chk("t2_wrap1", xf_id[xb + 5], 1);

        // back-pressure
        resp_ready = 1'b0;
        xb = xf_id.size();
        post(1, 12'h123);
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!resp_valid && n < 100);
        chk("t3_rv_seen", resp_valid, 1'b1);
        step(1);
        post(2, 12'h2A2);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            chk("t3_valid", resp_valid, 1'b1);
            chk("t3_id", resp_id, 1);
            chk("t3_q", resp_q, isqrt(12'h123));
            chk("t3_ready", req_ready, 0);
        end
        step(1);
        hb = hs_cyc.size();
        resp_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("t3_release", hs_cyc.size(), hb + 1);
        wait_hs("t3_next", hb + 2, 200);
        chk("t3_first", xf_id[xb], 1);
        chk("t3_second", xf_id[xb + 1], 2);

        // fairness with two streaming requesters
        xb = xf_id.size();
        keep[0] = 1'b1;
        keep[3] = 1'b1;
        post(0, 12'h0F0);
        post(3, 12'h30C);
        wait_xf("t4_grants", xb + 4, 400);
        chk("t4_g0", xf_id[xb + 0], 3);
        chk("t4_g1", xf_id[xb + 1], 0);
        chk("t4_g2", xf_id[xb + 2], 3);
        chk("t4_g3", xf_id[xb + 3], 0);
        keep = '0;
        drain(600);

        // reset while waiting on the datapath
        xb = xf_id.size();
        post(1, 12'h555);
        wait_xf("t5_xfer", xb + 1, 100);
        repeat (L - 4) @(posedge clk);
        #2;
        rb = rs_q.size();
        hb = hs_cyc.size();
        rst_ = 1'b1;
        #1;
        chk("t5_rst_outs", {req_ready, resp_valid, resp_id, resp_q,
                            sqrt_start, sqrt_a}, 64'd0);
        step(2);
        rst_ = 1'b0;
        step(40);
        chk("t5_no_resp", rs_q.size(), rb);
        chk("t5_no_hs", hs_cyc.size(), hb);
        post(2, 12'h0AB);
        wait_hs("t5_after", hb + 1, 200);
        chk("t5_id", rs_id[$], 2);
        chk("t5_q", rs_q[$], isqrt(12'h0AB));

        // edge radicands
        hb = hs_cyc.size();
        post(0, 12'h000);
        wait_hs("t6_zero_done", hb + 1, 200);
        chk("t6_zero", rs_q[$], 24'h000000);
        xb = xf_id.size();
        post(1, 12'hFFF);
        wait_xf("t6_xfer", xb + 1, 100);
        repeat (10) @(negedge clk);
        #1;
        chk("t6_a_hold", sqrt_a, 12'hFFF);
        wait_hs("t6_max_done", hb + 2, 200);
        chk("t6_max", rs_q[$], 24'hFFF7FF);

        // random traffic with random back-pressure
        for (int c = 0; c < 3000; c++) begin
            step(1);
            resp_ready = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 7) == 0) begin
                    case ($urandom_range(0, 5))
                        0:       a = 12'h000;
                        1:       a = 12'hFFF;
                        default: a = 12'($urandom);
                    endcase
                    post(i, a);
                end
            end
        end
        resp_ready = 1'b1;
        drain(1000);
        chk("jobs_balance", hs_cyc.size(), xf_cyc.size() - 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
